// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: multi-word instruction fetch controller with PC load, wrap and back-to-back fetch.
// Optional memory-wait timeout enabled by defining IF_TIMEOUT_EN.
module if_fetch_ctrl #(
    parameter int ADDR_W          = 16,
    parameter int WORD_W          = 16,
    parameter int WORDS_PER_INSTR = 2,
    parameter int TIMEOUT_CYC     = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              done,
    input  logic                              mfc,
    input  logic                              pc_load,
    input  logic [ADDR_W-1:0]                 pc_load_val,
    input  logic [WORD_W-1:0]                 mem_rdata,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic                              mem_en,
    output logic                              mem_rd,
    output logic [WORDS_PER_INSTR*WORD_W-1:0] ir,
    output logic                              ir_valid,
    output logic                              busy,
    output logic [ADDR_W-1:0]                 pc,
    output logic                              fault
);
    localparam int BW = $clog2(WORDS_PER_INSTR) + 1;
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, HOLD, FAULT} state_t;
    state_t state;
    logic [BW-1:0] beat;
    logic last;
    logic [ADDR_W-1:0] next_pc;
    assign last = beat == BW'(WORDS_PER_INSTR - 1);
    assign next_pc = pc_load ? pc_load_val : pc;
    assign mem_rd = mem_en;
`ifdef IF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wcnt;
    logic [ADDR_W-1:0] base_pc;
`else
    assign fault = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            beat     <= '0;
            mem_addr <= '0;
            mem_en   <= 1'b0;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
`ifdef IF_TIMEOUT_EN
            fault    <= 1'b0;
            wcnt     <= '0;
            base_pc  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pc <= next_pc;
                    if (start) begin
                        state <= ADDR;
                        busy  <= 1'b1;
                        beat  <= '0;
`ifdef IF_TIMEOUT_EN
                        base_pc <= next_pc;
`endif
                    end
                end
                ADDR: begin
                    mem_addr <= pc;
                    mem_en   <= 1'b1;
                    state    <= WAIT;
`ifdef IF_TIMEOUT_EN
                    wcnt     <= '0;
`endif
                end
                WAIT: if (mfc) begin
                    ir[int'(beat)*WORD_W +: WORD_W] <= mem_rdata;
                    pc     <= pc + ADDR_W'(1);
                    mem_en <= 1'b0;
                    if (last) begin
                        state    <= HOLD;
                        ir_valid <= 1'b1;
                    end else begin
                        beat  <= beat + BW'(1);
                        state <= ADDR;
                    end
                end
`ifdef IF_TIMEOUT_EN
                // Timeout restarts the whole instruction, so rewind pc to its first word.
                else if (wcnt == CW'(TIMEOUT_CYC - 1)) begin
                    state  <= FAULT;
                    mem_en <= 1'b0;
                    fault  <= 1'b1;
                    pc     <= base_pc;
                end else begin
                    wcnt <= wcnt + CW'(1);
                end
`endif
                HOLD: if (done) begin
                    ir_valid <= 1'b0;
                    pc       <= next_pc;
                    beat     <= '0;
                    if (start) begin
                        state <= ADDR;
`ifdef IF_TIMEOUT_EN
                        base_pc <= next_pc;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                FAULT: if (done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef IF_TIMEOUT_EN
                    fault <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed bench with a phase-level reference model checked every cycle.
module tb_if_fetch_ctrl;
    localparam int W  = 2;
    localparam int TO = 15;
    logic clk = 0, reset = 1, start = 0, done = 0, mfc = 0, pc_load = 0;
    logic [15:0] pc_load_val = '0, mem_rdata, mem_addr, pc;
    logic [31:0] ir;
    logic mem_en, mem_rd, ir_valid, busy, fault;
    int n_chk = 0, n_fail = 0;
    bit go = 0;
    if_fetch_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .mfc(mfc),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_rd(mem_rd), .ir(ir),
        .ir_valid(ir_valid), .busy(busy), .pc(pc), .fault(fault)
    );
    always #5 clk = ~clk;
    assign mem_rdata = 16'hA000 | mem_addr;
    // Reference model: a fetch is a sequence of 2*W phases (even = address, odd = wait).
    bit m_busy, m_valid, m_fault, m_en;
    logic [15:0] m_pc, m_addr, m_base;
    logic [31:0] m_ir;
    int m_step, m_wait;
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0; m_valid <= 0; m_fault <= 0; m_en <= 0;
            m_pc <= 0; m_addr <= 0; m_base <= 0; m_ir <= 0; m_step <= 0; m_wait <= 0;
        end else if (m_fault) begin
            if (done) begin m_fault <= 0; m_busy <= 0; end
        end else if (!m_busy) begin
            m_pc <= pc_load ? pc_load_val : m_pc;
            if (start) begin m_busy <= 1; m_step <= 0; m_base <= pc_load ? pc_load_val : m_pc; end
        end else if (m_valid) begin
            if (done) begin
                m_valid <= 0;
                m_pc <= pc_load ? pc_load_val : m_pc;
                if (start) begin m_step <= 0; m_base <= pc_load ? pc_load_val : m_pc; end
                else m_busy <= 0;
            end
        end else if (m_step % 2 == 0) begin
            m_addr <= m_pc; m_en <= 1; m_step <= m_step + 1; m_wait <= 0;
        end else if (mfc) begin
            m_ir[(m_step/2)*16 +: 16] <= 16'hA000 | m_addr;
            m_pc <= m_pc + 16'd1;
            m_en <= 0;
            if (m_step == 2*W - 1) m_valid <= 1;
            else m_step <= m_step + 1;
        end
`ifdef IF_TIMEOUT_EN
        else if (m_wait + 1 == TO) begin m_fault <= 1; m_en <= 0; m_pc <= m_base; end
        else m_wait <= m_wait + 1;
`endif
    end
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask
    always @(negedge clk) if (go) begin
        chk("m_mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("m_mem_en", 64'(mem_en), 64'(m_en));
        chk("m_mem_rd", 64'(mem_rd), 64'(m_en));
        chk("m_ir", 64'(ir), 64'(m_ir));
        chk("m_ir_valid", 64'(ir_valid), 64'(m_valid));
        chk("m_busy", 64'(busy), 64'(m_busy));
        chk("m_pc", 64'(pc), 64'(m_pc));
        chk("m_fault", 64'(fault), 64'(m_fault));
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    initial begin
        tick(); tick();
        reset = 0; go = 1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_pc", 64'(pc), 0);
        chk("rst_ir", 64'(ir), 0);
        // 1: basic two-word fetch with mfc held high
        mfc = 1; start = 1; tick(); start = 0;
        tick(); chk("t1_addr0", 64'(mem_addr), 64'h0000); chk("t1_en0", 64'(mem_en), 1);
        tick(); chk("t1_pc1", 64'(pc), 1);
        tick(); chk("t1_addr1", 64'(mem_addr), 64'h0001); chk("t1_valid3", 64'(ir_valid), 0);
        tick(); chk("t1_valid4", 64'(ir_valid), 1);
        chk("t1_ir", 64'(ir), 64'hA001_A000); chk("t1_pc", 64'(pc), 2);
        done = 1; tick(); done = 0;
        chk("t1_idle", 64'(busy), 0);
        // 2: beat 1 waits three cycles for mfc
        reset = 1; tick(); reset = 0;
        start = 1; tick(); start = 0;
        tick(); tick(); mfc = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_en", 64'(mem_en), 1); chk("t2_addr", 64'(mem_addr), 1);
            chk("t2_pc", 64'(pc), 1); chk("t2_ir_hi", 64'(ir[31:16]), 0);
        end
        mfc = 1; tick();
        chk("t2_ir", 64'(ir), 64'hA001_A000); chk("t2_en_off", 64'(mem_en), 0);
        done = 1; tick(); done = 0;
        // 3: load FFFF with start, PC wraps
        pc_load = 1; pc_load_val = 16'hFFFF; start = 1; tick(); pc_load = 0; start = 0;
        tick(); chk("t3_addr0", 64'(mem_addr), 64'hFFFF);
        tick(); chk("t3_pc_wrap", 64'(pc), 0);
        tick(); chk("t3_addr1", 64'(mem_addr), 64'h0000);
        tick(); chk("t3_pc", 64'(pc), 1); chk("t3_ir", 64'(ir), 64'hA000_FFFF);
        // 4: back-to-back fetch from HOLD
        done = 1; start = 1; tick(); done = 0; start = 0;
        chk("t4_valid", 64'(ir_valid), 0); chk("t4_busy", 64'(busy), 1);
        tick(); chk("t4_addr", 64'(mem_addr), 1); chk("t4_busy2", 64'(busy), 1);
        tick(); tick(); tick();
        chk("t4_ir", 64'(ir), 64'hA002_A001); chk("t4_pc", 64'(pc), 3);
        done = 1; tick(); done = 0;
        // 5: ignored pc_load/done mid-fetch, then reset in beat-1 WAIT
        start = 1; tick(); start = 0;
        tick(); tick(); mfc = 0; pc_load = 1; pc_load_val = 16'h1234; done = 1;
        tick(); tick(); pc_load = 0; done = 0;
        chk("t5_pc_ign", 64'(pc), 4);
        reset = 1; tick(); reset = 0;
        chk("t5_busy", 64'(busy), 0); chk("t5_pc", 64'(pc), 0); chk("t5_ir", 64'(ir), 0);
        chk("t5_en", 64'(mem_en), 0); chk("t5_addr", 64'(mem_addr), 0);
        mfc = 1; tick(); tick();
        chk("t5_mfc_ign", 64'(busy), 0); chk("t5_pc2", 64'(pc), 0);
        // pc_load on HOLD release without start
        start = 1; tick(); start = 0;
        tick(); tick(); tick(); tick();
        done = 1; pc_load = 1; pc_load_val = 16'h0100; tick(); done = 0; pc_load = 0;
        chk("hold_load_pc", 64'(pc), 64'h0100); chk("hold_load_idle", 64'(busy), 0);
        tick();
`ifdef IF_TIMEOUT_EN
        // 6: memory never answers
        mfc = 0; pc_load = 1; pc_load_val = 16'h0010; start = 1; tick(); pc_load = 0; start = 0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        chk("t6_nofault", 64'(fault), 0);
        tick();
        chk("t6_fault", 64'(fault), 1); chk("t6_en", 64'(mem_en), 0); chk("t6_pc", 64'(pc), 64'h0010);
        done = 1; tick(); done = 0;
        chk("t6_clr", 64'(fault), 0); chk("t6_idle", 64'(busy), 0);
`endif
        tick();
        go = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
